// File: rtl/music_req_arbiter.sv
// Fixed-priority arbiter sharing one musicplayer between several requesters.
// Each grant plays for a fixed time, then a silent gap precedes the next grant.
module music_req_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned PLAY_MS  = 2000,
  parameter int unsigned GAP_MS   = 100,
  parameter bit          PREEMPT  = 1'b1
) (
  input  logic                   clk,
  input  logic                   enable,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*SEL_W-1:0] sel_in,
  input  logic                   cancel,
  output logic [SEL_W-1:0]       music_sel,
  output logic                   music_en,
  output logic [N_REQ-1:0]       grant,
  output logic                   busy,
  output logic [N_REQ-1:0]       done
);

  localparam int unsigned PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MS_MAX = (PLAY_MS > GAP_MS) ? PLAY_MS : GAP_MS;
  localparam int unsigned MW     = (MS_MAX > 1) ? $clog2(MS_MAX + 1) : 1;
  localparam int unsigned IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [MW-1:0] PLAY_LAST  = MW'(PLAY_MS - 1);
  localparam logic [MW-1:0] GAP_LAST   = MW'(GAP_MS - 1);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e                 state_q, state_d;
  logic [N_REQ-1:0]       pending_q, pending_d;
  logic [SEL_W-1:0]       sel_q [N_REQ];
  logic [SEL_W-1:0]       sel_d [N_REQ];
  logic [IW-1:0]          owner_q, owner_d;
  logic [PW-1:0]          presc_q, presc_d;
  logic [MW-1:0]          ms_q, ms_d;
  logic [SEL_W-1:0]       music_sel_q, music_sel_d;
  logic                   music_en_q, music_en_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic [N_REQ-1:0]       done_q, done_d;

  logic [N_REQ-1:0] cand;
  logic [IW-1:0]    win_idx;
  logic             win_vld;
  logic [SEL_W-1:0] win_sel;
  logic             preempt_hit;
  logic             tick_last;
  logic [PW-1:0]    presc_step;
  logic [MW-1:0]    ms_step;

  // Current-cycle requests compete alongside latched ones.
  assign cand = pending_q | req;

  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        win_idx = IW'(i);
        win_vld = 1'b1;
      end
    end
  end

  assign win_sel = req[win_idx] ? sel_in[win_idx*SEL_W +: SEL_W] : sel_q[win_idx];

  always_comb begin
    preempt_hit = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (cand[i] && (IW'(i) < owner_q)) preempt_hit = 1'b1;
    end
  end

  assign tick_last  = (presc_q == PRESC_LAST);
  assign presc_step = tick_last ? '0 : presc_q + 1'b1;
  assign ms_step    = tick_last ? ms_q + 1'b1 : ms_q;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    sel_d       = sel_q;
    owner_d     = owner_q;
    presc_d     = presc_step;
    ms_d        = ms_step;
    music_sel_d = music_sel_q;
    music_en_d  = music_en_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    done_d      = '0;

    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) begin
        pending_d[i] = 1'b1;
        sel_d[i]     = sel_in[i*SEL_W +: SEL_W];
      end
    end

    unique case (state_q)
      StIdle: begin
        presc_d = '0;
        ms_d    = '0;
        if (win_vld) begin
          state_d            = StPlay;
          owner_d            = win_idx;
          pending_d[win_idx] = 1'b0;
          music_sel_d        = win_sel;
          music_en_d         = 1'b1;
          busy_d             = 1'b1;
          for (int i = 0; i < N_REQ; i++) grant_d[i] = (IW'(i) == win_idx);
        end
      end
      StPlay: begin
        // A tune that reaches its last cycle completes even if a preemptor arrives.
        if (tick_last && (ms_q == PLAY_LAST)) begin
          state_d    = StGap;
          done_d     = grant_q;
          music_en_d = 1'b0;
          grant_d    = '0;
          presc_d    = '0;
          ms_d       = '0;
        end else if (PREEMPT && preempt_hit) begin
          state_d    = StGap;
          music_en_d = 1'b0;
          grant_d    = '0;
          presc_d    = '0;
          ms_d       = '0;
        end
      end
      StGap: begin
        if (tick_last && (ms_q == GAP_LAST)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          presc_d = '0;
          ms_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Cancel discards same-cycle requests as well as everything pending.
    if (cancel) begin
      state_d    = StIdle;
      pending_d  = '0;
      sel_d      = sel_q;
      music_en_d = 1'b0;
      grant_d    = '0;
      busy_d     = 1'b0;
      done_d     = '0;
      presc_d    = '0;
      ms_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      sel_q       <= '{default: '0};
      owner_q     <= '0;
      presc_q     <= '0;
      ms_q        <= '0;
      music_sel_q <= '0;
      music_en_q  <= 1'b0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      sel_q       <= sel_d;
      owner_q     <= owner_d;
      presc_q     <= presc_d;
      ms_q        <= ms_d;
      music_sel_q <= music_sel_d;
      music_en_q  <= music_en_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign music_sel = music_sel_q;
  assign music_en  = music_en_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_music_req_arbiter.sv
// Directed bench for music_req_arbiter: one preempting and one non-preempting
// instance share stimulus; per-cycle expected outputs come from scoreboard queues.
module tb_music_req_arbiter;

  logic        clk = 1'b0;
  logic        enable;
  logic        cancel = 1'b0;
  logic [3:0]  req = '0;
  logic [11:0] sel_in = '0;

  logic [2:0] sel_p, sel_n;
  logic       en_p, en_n, busy_p, busy_n;
  logic [3:0] grant_p, grant_n, done_p, done_n;

  typedef struct packed {
    logic       en;
    logic [3:0] grant;
    logic       busy;
    logic [3:0] done;
    logic [2:0] sel;
  } exp_t;

  exp_t qp[$];
  exp_t qn[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  music_req_arbiter #(
    .N_REQ(4), .SEL_W(3), .TICK_DIV(4), .PLAY_MS(5), .GAP_MS(2), .PREEMPT(1'b1)
  ) dut_p (
    .clk(clk), .enable(enable), .req(req), .sel_in(sel_in), .cancel(cancel),
    .music_sel(sel_p), .music_en(en_p), .grant(grant_p), .busy(busy_p), .done(done_p)
  );

  music_req_arbiter #(
    .N_REQ(4), .SEL_W(3), .TICK_DIV(4), .PLAY_MS(5), .GAP_MS(2), .PREEMPT(1'b0)
  ) dut_n (
    .clk(clk), .enable(enable), .req(req), .sel_in(sel_in), .cancel(cancel),
    .music_sel(sel_n), .music_en(en_n), .grant(grant_n), .busy(busy_n), .done(done_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input bit tp, input bit tn, input int n, input logic en,
                      input logic [3:0] g, input logic b, input logic [3:0] d,
                      input logic [2:0] s);
    exp_t e;
    e.en = en; e.grant = g; e.busy = b; e.done = d; e.sel = s;
    for (int i = 0; i < n; i++) begin
      if (tp) qp.push_back(e);
      if (tn) qn.push_back(e);
    end
  endtask

  task automatic play(input bit tp, input bit tn, input int n, input logic [3:0] g,
                      input logic [2:0] s);
    push(tp, tn, n, 1'b1, g, 1'b1, 4'b0, s);
  endtask

  // Gap of 8 cycles; the first carries the done pulse (d may be 0 after an abort).
  task automatic gap(input bit tp, input bit tn, input logic [3:0] d, input logic [2:0] s);
    push(tp, tn, 1, 1'b0, 4'b0, 1'b1, d, s);
    push(tp, tn, 7, 1'b0, 4'b0, 1'b1, 4'b0, s);
  endtask

  task automatic idle(input bit tp, input bit tn, input int n, input logic [2:0] s);
    push(tp, tn, n, 1'b0, 4'b0, 1'b0, 4'b0, s);
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    chk("sb_p_avail", 32'(qp.size() > 0), 32'd1);
    if (qp.size() > 0) begin
      e = qp.pop_front();
      chk("p_en", 32'(en_p), 32'(e.en));
      chk("p_grant", 32'(grant_p), 32'(e.grant));
      chk("p_busy", 32'(busy_p), 32'(e.busy));
      chk("p_done", 32'(done_p), 32'(e.done));
      chk("p_sel", 32'(sel_p), 32'(e.sel));
    end
    chk("sb_n_avail", 32'(qn.size() > 0), 32'd1);
    if (qn.size() > 0) begin
      e = qn.pop_front();
      chk("n_en", 32'(en_n), 32'(e.en));
      chk("n_grant", 32'(grant_n), 32'(e.grant));
      chk("n_busy", 32'(busy_n), 32'(e.busy));
      chk("n_done", 32'(done_n), 32'(e.done));
      chk("n_sel", 32'(sel_n), 32'(e.sel));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic drain();
    int guard = 0;
    while ((qp.size() > 0 || qn.size() > 0) && guard < 1000) begin
      cyc();
      guard++;
    end
    chk("drain_bound", 32'(guard < 1000), 32'd1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_p_en"}, 32'(en_p), 32'd0);
    chk({tag, "_p_grant"}, 32'(grant_p), 32'd0);
    chk({tag, "_p_busy"}, 32'(busy_p), 32'd0);
    chk({tag, "_p_done"}, 32'(done_p), 32'd0);
    chk({tag, "_n_en"}, 32'(en_n), 32'd0);
    chk({tag, "_n_grant"}, 32'(grant_n), 32'd0);
    chk({tag, "_n_busy"}, 32'(busy_n), 32'd0);
    chk({tag, "_n_done"}, 32'(done_n), 32'd0);
  endtask

  initial begin
    enable = 1'b1;
    #1 enable = 1'b0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    chk("reset_p_sel", 32'(sel_p), 32'd0);
    chk("reset_n_sel", 32'(sel_n), 32'd0);
    enable = 1'b1;
    idle(1, 1, 2, 3'd0);
    run(2);

    // Single request from requester 2.
    sel_in = 12'(5) << 6;
    req    = 4'b0100;
    play(1, 1, 20, 4'b0100, 3'd5);
    gap(1, 1, 4'b0100, 3'd5);
    idle(1, 1, 3, 3'd5);
    cyc();
    req = '0;
    sel_in = '0;
    drain();

    // Simultaneous requests 1 and 3; slice 3 must be the latched value.
    sel_in = (12'(6) << 9) | (12'(3) << 3);
    req    = 4'b1010;
    play(1, 1, 20, 4'b0010, 3'd3);
    gap(1, 1, 4'b0010, 3'd3);
    idle(1, 1, 1, 3'd3);
    play(1, 1, 20, 4'b1000, 3'd6);
    gap(1, 1, 4'b1000, 3'd6);
    idle(1, 1, 2, 3'd6);
    cyc();
    req = '0;
    sel_in = 12'hfff;
    drain();
    sel_in = '0;

    // Requester 0 arrives while 3 plays: aborts only on the preempting instance.
    sel_in = 12'(2) << 9;
    req    = 4'b1000;
    play(1, 0, 9, 4'b1000, 3'd2);
    gap(1, 0, 4'b0000, 3'd2);
    idle(1, 0, 1, 3'd2);
    play(1, 0, 20, 4'b0001, 3'd7);
    gap(1, 0, 4'b0001, 3'd7);
    idle(1, 0, 13, 3'd7);
    play(0, 1, 20, 4'b1000, 3'd2);
    gap(0, 1, 4'b1000, 3'd2);
    idle(0, 1, 1, 3'd2);
    play(0, 1, 20, 4'b0001, 3'd7);
    gap(0, 1, 4'b0001, 3'd7);
    idle(0, 1, 2, 3'd7);
    cyc();
    req = '0;
    sel_in = '0;
    run(8);
    req = 4'b0001;
    sel_in = 12'd7;
    cyc();
    req = '0;
    sel_in = '0;
    drain();

    // Cancel with a same-cycle request during play.
    sel_in = 12'(4) << 6;
    req    = 4'b0100;
    play(1, 1, 5, 4'b0100, 3'd4);
    idle(1, 1, 51, 3'd4);
    cyc();
    req = '0;
    sel_in = '0;
    run(4);
    cancel = 1'b1;
    req    = 4'b0010;
    sel_in = 12'(1) << 3;
    cyc();
    cancel = 1'b0;
    req    = '0;
    sel_in = '0;
    drain();

    // Asynchronous reset between edges during play.
    sel_in = 12'd6;
    req    = 4'b0001;
    play(1, 1, 4, 4'b0001, 3'd6);
    cyc();
    req = '0;
    sel_in = '0;
    run(3);
    #2 enable = 1'b0;
    #1 chk_quiet("async_rst");
    @(posedge clk);
    @(negedge clk);
    enable = 1'b1;
    idle(1, 1, 30, 3'd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
